// File: rtl/uart_frame_loader_if.sv
// Wishbone classic bus between uart_frame_loader (master) and the 16550-style UART core (slave).
interface uart_frame_loader_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/uart_frame_loader.sv
// Initialises a 16550-style UART over Wishbone, then loads sync-marked 1bpp frames into a framebuffer port.
// Optional FRAME_CHECKSUM_EN: an XOR trailer byte follows each payload and gates frame_done_o.
module uart_frame_loader #(
    parameter logic [15:0] DIVISOR        = 16'd35,
    parameter int          FRAME_BYTES_X  = 128,
    parameter int          FRAME_LINES    = 768,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int          TIMEOUT_CYCLES = 650000,
    parameter int          XW             = 7,
    parameter int          YW             = 10
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    uart_frame_loader_if.master wb,
    input  logic                uart_irq_i,
    output logic                fb_we_o,
    output logic [XW-1:0]       fb_x_o,
    output logic [YW-1:0]       fb_y_o,
    output logic [7:0]          fb_d_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic                frame_err_o
);
    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_HUNT    = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CSUM    = 2'd3;

    localparam int            TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [XW-1:0] X_LAST    = XW'(FRAME_BYTES_X - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(FRAME_LINES - 1);
    localparam logic [2:0]    INIT_LAST = 3'd5;

    typedef struct packed {
        logic [2:0] adr;
        logic [7:0] dat;
    } wb_op_t;

    // DLAB on, divisor low/high, 8N1 with DLAB off, FIFOs off, RX-data IRQ on
    function automatic wb_op_t init_op(input logic [2:0] idx);
        case (idx)
            3'd0:    init_op = '{adr: 3'd3, dat: 8'h83};
            3'd1:    init_op = '{adr: 3'd0, dat: DIVISOR[7:0]};
            3'd2:    init_op = '{adr: 3'd1, dat: DIVISOR[15:8]};
            3'd3:    init_op = '{adr: 3'd3, dat: 8'h03};
            3'd4:    init_op = '{adr: 3'd2, dat: 8'h00};
            default: init_op = '{adr: 3'd1, dat: 8'h01};
        endcase
    endfunction

    logic [1:0]    state_q, state_d;
    logic [2:0]    init_idx_q, init_idx_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [2:0]    adr_q, adr_d;
    logic [7:0]    dat_q, dat_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          fb_we_q, fb_we_d;
    logic [XW-1:0] fb_x_q, fb_x_d;
    logic [YW-1:0] fb_y_q, fb_y_d;
    logic [7:0]    fb_d_q, fb_d_d;
    logic [7:0]    csum_q, csum_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fin_q, fin_d;
    logic [TW-1:0] tmo_q, tmo_d;

    wb_op_t     op;
    logic       ack_ok;
    logic       bus_err;
    logic       tmo_hit;
    logic       last_byte;
    logic [7:0] rx_byte;
    logic       unused_dat;

    assign op         = init_op(init_idx_q);
    assign rx_byte    = wb.wb_dat_i[7:0];
    assign unused_dat = ^wb.wb_dat_i[31:8];
    assign ack_ok     = cyc_q && wb.wb_ack_i && !wb.wb_err_i;
    assign bus_err    = cyc_q && wb.wb_err_i;
    assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
    assign last_byte  = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        x_d        = x_q;
        y_d        = y_q;
        fb_we_d    = 1'b0;
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_d_d     = fb_d_q;
        csum_d     = csum_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fin_d      = 1'b0;
        tmo_d      = tmo_q;

        // the cycle after a response is always idle; a new request may only be decided there
        if (ack_ok || bus_err) cyc_d = 1'b0;

        // last payload write went out this cycle, so completion shows one cycle later
        if (fin_q) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    adr_d = op.adr;
                    dat_d = op.dat;
                end else if (ack_ok) begin
                    if (init_idx_q == INIT_LAST) begin
                        init_idx_d = 3'd0;
                        state_d    = ST_HUNT;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                if (!cyc_q && uart_irq_i) begin
                    cyc_d = 1'b1;
                    we_d  = 1'b0;
                    adr_d = 3'd0;
                    dat_d = 8'h00;
                end
                if (state_q == ST_HUNT) begin
                    if (ack_ok && (rx_byte == SYNC_BYTE)) begin
                        busy_d  = 1'b1;
                        x_d     = '0;
                        y_d     = '0;
                        csum_d  = 8'h00;
                        tmo_d   = '0;
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    if (TIMEOUT_CYCLES != 0) tmo_d = tmo_q + 1'b1;
                    if (ack_ok) begin
                        tmo_d = '0;
                        if (state_q == ST_PAYLOAD) begin
                            fb_we_d = 1'b1;
                            fb_d_d  = rx_byte;
                            fb_x_d  = x_q;
                            fb_y_d  = y_q;
                            csum_d  = csum_q ^ rx_byte;
                            if (last_byte) begin
                                x_d = '0;
                                y_d = '0;
`ifdef FRAME_CHECKSUM_EN
                                state_d = ST_CSUM;
`else
                                fin_d   = 1'b1;
                                state_d = ST_HUNT;
`endif
                            end else if (x_q == X_LAST) begin
                                x_d = '0;
                                y_d = y_q + 1'b1;
                            end else begin
                                x_d = x_q + 1'b1;
                            end
                        end else begin
                            if (rx_byte == csum_q) done_d = 1'b1;
                            else                   err_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_HUNT;
                        end
                    end else if (bus_err || tmo_hit) begin
                        // already-written lines stay in the framebuffer
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_HUNT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= ST_INIT;
            init_idx_q <= 3'd0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 3'd0;
            dat_q      <= 8'h00;
            x_q        <= '0;
            y_q        <= '0;
            fb_we_q    <= 1'b0;
            fb_x_q     <= '0;
            fb_y_q     <= '0;
            fb_d_q     <= 8'h00;
            csum_q     <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fin_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fb_we_q    <= fb_we_d;
            fb_x_q     <= fb_x_d;
            fb_y_q     <= fb_y_d;
            fb_d_q     <= fb_d_d;
            csum_q     <= csum_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fin_q      <= fin_d;
            tmo_q      <= tmo_d;
        end
    end

    assign wb.wb_adr_o  = {29'd0, adr_q};
    assign wb.wb_dat_o  = {24'd0, dat_q};
    assign wb.wb_sel_o  = 4'b0001;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = cyc_q;

    assign fb_we_o      = fb_we_q;
    assign fb_x_o       = fb_x_q;
    assign fb_y_o       = fb_y_q;
    assign fb_d_o       = fb_d_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = err_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomised bench for uart_frame_loader: Wishbone UART slave model, framebuffer monitor, frame-level reference.
module tb_uart_frame_loader;
    localparam int BX  = 8;
    localparam int BL  = 4;
    localparam int N   = BX * BL;
    localparam int TMO = 300;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       irq;
    logic       fb_we;
    logic [2:0] fb_x;
    logic [1:0] fb_y;
    logic [7:0] fb_d;
    logic       busy;
    logic       done;
    logic       ferr;

    uart_frame_loader_if bus ();

    uart_frame_loader #(
        .DIVISOR(16'd35), .FRAME_BYTES_X(BX), .FRAME_LINES(BL), .SYNC_BYTE(8'hAA),
        .TIMEOUT_CYCLES(TMO), .XW(3), .YW(2)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb(bus), .uart_irq_i(irq),
        .fb_we_o(fb_we), .fb_x_o(fb_x), .fb_y_o(fb_y), .fb_d_o(fb_d),
        .busy_o(busy), .frame_done_o(done), .frame_err_o(ferr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // UART byte source: main writes stim/stim_wr, slave owns stim_rd
    logic [7:0]  stim [0:4095];
    int          stim_wr = 0;
    int          stim_rd = 0;
    // transaction log {err, we, adr[3:0], dat}, owned by the slave
    logic [13:0] log_e [0:4095];
    int          log_n = 0;
    int          wr_n = 0;
    int          rd_n = 0;
    int          err_wr_at = -1;
    int          err_rd_at = -1;

    task automatic push(input logic [7:0] b);
        stim[stim_wr] = b;
        stim_wr++;
    endtask

    function automatic logic [13:0] mk(input bit e, input bit w, input logic [3:0] a, input logic [7:0] d);
        return {e, w, a, d};
    endfunction

    initial begin : slave
        bit e;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = '0;
        irq = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.wb_ack_i || bus.wb_err_i) begin
                bus.wb_ack_i = 1'b0;
                bus.wb_err_i = 1'b0;
            end else if (rst_n && bus.wb_cyc_o && bus.wb_stb_o) begin
                if (bus.wb_we_o) begin
                    wr_n++;
                    e = (wr_n == err_wr_at);
                    log_e[log_n] = mk(e, 1'b1, bus.wb_adr_o[3:0], bus.wb_dat_o[7:0]);
                end else begin
                    rd_n++;
                    e = (rd_n == err_rd_at);
                    log_e[log_n] = mk(e, 1'b0, bus.wb_adr_o[3:0], 8'h00);
                    if (!e && stim_rd != stim_wr) begin
                        bus.wb_dat_i = {24'h0, stim[stim_rd]};
                        stim_rd++;
                    end
                end
                log_n++;
                if (e) bus.wb_err_i = 1'b1;
                else   bus.wb_ack_i = 1'b1;
            end
            irq = (stim_rd != stim_wr);
        end
    end

    // framebuffer / status monitor
    int         obs_x [0:1023];
    int         obs_y [0:1023];
    logic [7:0] obs_d [0:1023];
    int         fb_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         shape_bad = 0;

    initial begin : monitor
        bit prev_we, prev_done, prev_err;
        prev_we = 0; prev_done = 0; prev_err = 0;
        forever begin
            @(negedge clk);
            if (fb_we) begin
                obs_x[fb_cnt] = int'(fb_x);
                obs_y[fb_cnt] = int'(fb_y);
                obs_d[fb_cnt] = fb_d;
                fb_cnt++;
            end
            if (done) done_cnt++;
            if (ferr) err_cnt++;
            if (!CSUM_ON && done && !prev_we) shape_bad++;
            if ((done && prev_done) || (ferr && prev_err) || (fb_we && prev_we)) shape_bad++;
            prev_we = fb_we; prev_done = done; prev_err = ferr;
        end
    end

    bit saw_busy;

    task automatic wait_evt(input int d0, input int e0, output bit ok);
        ok = 0;
        saw_busy = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (busy) saw_busy = 1;
            if (done_cnt != d0 || err_cnt != e0) ok = 1;
        end
    endtask

    task automatic check_writes(input int f0, input int cnt, input logic [7:0] pl [N]);
        for (int i = 0; i < cnt; i++) begin
            chk("fb_x", obs_x[f0+i], i % BX);
            chk("fb_y", obs_y[f0+i], i / BX);
            chk("fb_d", obs_d[f0+i], pl[i]);
        end
    endtask

    task automatic run_frame(input bit bad_csum);
        logic [7:0] pl [N];
        logic [7:0] x;
        int f0, d0, e0;
        bit ok, exp_err;
        for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
        pl[3] = 8'hAA;
        x = 8'h00;
        for (int i = 0; i < N; i++) x ^= pl[i];
        exp_err = CSUM_ON && bad_csum;
        f0 = fb_cnt; d0 = done_cnt; e0 = err_cnt;
        push(8'h55);
        push(8'hAA);
        for (int i = 0; i < N; i++) push(pl[i]);
        if (CSUM_ON) push(bad_csum ? (x ^ 8'h01) : x);
        wait_evt(d0, e0, ok);
        chk("frame_wait", ok, 1);
        chk("frame_busy_seen", saw_busy, 1);
        repeat (6) @(negedge clk);
        chk("frame_fb_cnt", fb_cnt - f0, N);
        check_writes(f0, N, pl);
        chk("frame_done", done_cnt - d0, exp_err ? 0 : 1);
        chk("frame_err", err_cnt - e0, exp_err ? 1 : 0);
        chk("frame_busy_end", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        logic [13:0] exp_init [0:5];
        logic [7:0]  pl [N];
        int base, f0, d0, e0;
        bit ok;

        exp_init[0] = mk(0, 1, 4'd3, 8'h83);
        exp_init[1] = mk(0, 1, 4'd0, 8'h23);
        exp_init[2] = mk(0, 1, 4'd1, 8'h00);
        exp_init[3] = mk(0, 1, 4'd3, 8'h03);
        exp_init[4] = mk(0, 1, 4'd2, 8'h00);
        exp_init[5] = mk(0, 1, 4'd1, 8'h01);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc", bus.wb_cyc_o, 0);
        chk("rst_stb", bus.wb_stb_o, 0);
        chk("rst_we", bus.wb_we_o, 0);
        chk("rst_adr", bus.wb_adr_o, 0);
        chk("rst_dat", bus.wb_dat_o, 0);
        chk("rst_sel", bus.wb_sel_o, 4'b0001);
        chk("rst_fb", {fb_we, fb_x, fb_y, fb_d}, 0);
        chk("rst_stat", {busy, done, ferr}, 0);

        // IRQ already pending: no read may appear before the init writes complete
        push(8'h55);
        base = log_n;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("init_len", log_n - base, 7);
        for (int i = 0; i < 6; i++) chk("init_wr", log_e[base+i], exp_init[i]);
        chk("init_then_rd", log_e[base+6], mk(0, 0, 4'd0, 8'h00));

        // bus error on the 2nd init write: that write is retried
        do_reset();
        err_wr_at = wr_n + 2;
        base = log_n;
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("ierr_len", log_n - base, 7);
        chk("ierr_wr0", log_e[base], exp_init[0]);
        chk("ierr_err", log_e[base+1], mk(1, 1, 4'd0, 8'h23));
        for (int i = 1; i < 6; i++) chk("ierr_wr", log_e[base+1+i], exp_init[i]);

        run_frame(1'b0);
        run_frame(1'b0);

        // timeout: sync, 10 bytes, then silence
        for (int i = 0; i < N; i++) pl[i] = 8'($urandom);
        f0 = fb_cnt; d0 = done_cnt; e0 = err_cnt;
        push(8'hAA);
        for (int i = 0; i < 10; i++) push(pl[i]);
        wait_evt(d0, e0, ok);
        chk("tmo_wait", ok, 1);
        repeat (4) @(negedge clk);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_done", done_cnt - d0, 0);
        chk("tmo_fb_cnt", fb_cnt - f0, 10);
        check_writes(f0, 10, pl);
        chk("tmo_busy", busy, 0);
        run_frame(1'b0);

        // bus error on the 10th payload read: 9 writes, abort, rest discarded in hunt
        for (int i = 0; i < N; i++) pl[i] = 8'($urandom_range(0, 169));
        f0 = fb_cnt; d0 = done_cnt; e0 = err_cnt;
        err_rd_at = rd_n + 11;
        push(8'hAA);
        for (int i = 0; i < 12; i++) push(pl[i]);
        wait_evt(d0, e0, ok);
        chk("berr_wait", ok, 1);
        repeat (60) @(negedge clk);
        chk("berr_err", err_cnt - e0, 1);
        chk("berr_done", done_cnt - d0, 0);
        chk("berr_fb_cnt", fb_cnt - f0, 9);
        check_writes(f0, 9, pl);
        chk("berr_busy", busy, 0);
        chk("berr_drained", stim_wr - stim_rd, 0);

        if (CSUM_ON) run_frame(1'b1);
        run_frame(1'b0);

        chk("pulse_shape", shape_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
